// File: rtl/alu_ctrl_decoder.sv
// rtl/alu_ctrl_decoder.sv - RV32 ALU-op decoder behind a 2-entry skid buffer.
// Optional delivery statistics (op_count, illegal_count) under `ALU_DECODE_STATS_EN.
module alu_ctrl_decoder #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_ctrl,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm,
  output logic            use_imm,
  output logic            illegal
`ifdef ALU_DECODE_STATS_EN
  ,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] illegal_count
`endif
);

  typedef struct packed {
    logic [3:0]      alu_ctrl;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t  state, state_nxt;
  bundle_t dec, main_q, skid_q;
  logic    accept, deliver;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [3:0] base_op;
  logic [3:0] ctl;
  logic       sel_imm, bad;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    base_op = 4'h1;
    case (funct3)
      3'b000:  base_op = 4'h1;
      3'b001:  base_op = 4'h3;
      3'b010:  base_op = 4'h6;
      3'b011:  base_op = 4'h7;
      3'b100:  base_op = 4'h8;
      3'b101:  base_op = 4'h4;
      3'b110:  base_op = 4'h9;
      default: base_op = 4'hA;
    endcase
  end

  // Every illegal encoding collapses to the same neutral control (ADD, register operand).
  always_comb begin
    ctl     = base_op;
    sel_imm = 1'b0;
    bad     = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          ctl = base_op;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          ctl = 4'h2;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          ctl = 4'h5;
        end else begin
          bad = 1'b1;
        end
      end
      7'b0010011: begin
        sel_imm = 1'b1;
        if (funct3 == 3'b001) begin
          bad = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000) begin
            ctl = 4'h5;
          end else if (funct7 != 7'b0000000) begin
            bad = 1'b1;
          end
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctl     = 4'h1;
      sel_imm = 1'b0;
    end
  end

  always_comb begin
    dec          = '0;
    dec.alu_ctrl = ctl;
    dec.rd       = inst[11:7];
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.imm      = {{(XLEN-12){inst[31]}}, inst[31:20]};
    dec.use_imm  = sel_imm;
    dec.illegal  = bad;
  end

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !deliver) begin
          state_nxt = TWO;
        end else if (!accept && deliver) begin
          state_nxt = EMPTY;
        end
      end
      TWO:     if (deliver) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake flags decode registered state only, so out_ready never reaches in_ready.
  always_comb begin
    out_valid = (state != EMPTY);
    in_ready  = (state != TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q          <= '0;
      main_q.alu_ctrl <= 4'h1;
      skid_q          <= '0;
      skid_q.alu_ctrl <= 4'h1;
    end else begin
      case (state)
        EMPTY: if (accept) main_q <= dec;
        ONE: begin
          if (accept && deliver) begin
            main_q <= dec;
          end else if (accept) begin
            skid_q <= dec;
          end
        end
        TWO:     if (deliver) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign alu_ctrl = main_q.alu_ctrl;
  assign rd       = main_q.rd;
  assign rs1      = main_q.rs1;
  assign rs2      = main_q.rs2;
  assign imm      = main_q.imm;
  assign use_imm  = main_q.use_imm;
  assign illegal  = main_q.illegal;

`ifdef ALU_DECODE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count      <= '0;
      illegal_count <= '0;
    end else if (deliver) begin
      if (op_count != {CNT_W{1'b1}}) op_count <= op_count + 1'b1;
      if (main_q.illegal && illegal_count != {CNT_W{1'b1}}) begin
        illegal_count <= illegal_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// tb/tb_alu_ctrl_decoder.sv - directed vector bench for alu_ctrl_decoder.
module tb_alu_ctrl_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        use_imm;
  logic        illegal;
`ifdef ALU_DECODE_STATS_EN
  logic [15:0] op_count;
  logic [15:0] illegal_count;
`endif

  int errors = 0;
  int checks = 0;

  alu_ctrl_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .use_imm(use_imm), .illegal(illegal)
`ifdef ALU_DECODE_STATS_EN
    , .op_count(op_count), .illegal_count(illegal_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  alu;
    logic        ui;
    logic        il;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ctl;
  } vec_t;

  vec_t tbl[$];

  // Control fields of illegal R/I encodings are don't-care, masked off via ctl = 0.
  localparam logic [63:0] CTL_MASK = 64'h001F_0000_0000_0000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pk();
    return {9'd0, in_ready, out_valid, alu_ctrl, use_imm, illegal, rd, rs1, rs2, imm};
  endfunction

  function automatic logic [63:0] ep(input logic ir, input logic ov, input logic [3:0] alu,
                                     input logic ui, input logic il, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [4:0] s2,
                                     input logic [31:0] im);
    return {9'd0, ir, ov, alu, ui, il, d, s1, s2, im};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl.push_back('{32'h003100B3, 4'h1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h003, 1'b1});
    tbl.push_back('{32'h402081B3, 4'h2, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h402, 1'b1});
    tbl.push_back('{32'h003110B3, 4'h3, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h003, 1'b1});
    tbl.push_back('{32'h003120B3, 4'h6, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h003, 1'b1});
    tbl.push_back('{32'h003130B3, 4'h7, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h003, 1'b1});
    tbl.push_back('{32'h003140B3, 4'h8, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h003, 1'b1});
    tbl.push_back('{32'h003150B3, 4'h4, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h003, 1'b1});
    tbl.push_back('{32'h407352B3, 4'h5, 1'b0, 1'b0, 5'd5, 5'd6, 5'd7, 32'h407, 1'b1});
    tbl.push_back('{32'h003160B3, 4'h9, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h003, 1'b1});
    tbl.push_back('{32'h003170B3, 4'hA, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h003, 1'b1});
    tbl.push_back('{32'h023100B3, 4'h0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'h023, 1'b0});
    tbl.push_back('{32'h403140B3, 4'h0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'h403, 1'b0});
    tbl.push_back('{32'hFFF00093, 4'h1, 1'b1, 1'b0, 5'd1, 5'd0, 5'd31, 32'hFFFFFFFF, 1'b1});
    tbl.push_back('{32'h40010093, 4'h1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 32'h400, 1'b1});
    tbl.push_back('{32'h80012093, 4'h6, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFFF800, 1'b1});
    tbl.push_back('{32'h00113093, 4'h7, 1'b1, 1'b0, 5'd1, 5'd2, 5'd1, 32'h001, 1'b1});
    tbl.push_back('{32'h0FF14093, 4'h8, 1'b1, 1'b0, 5'd1, 5'd2, 5'd31, 32'h0FF, 1'b1});
    tbl.push_back('{32'h12316093, 4'h9, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'h123, 1'b1});
    tbl.push_back('{32'h00F17093, 4'hA, 1'b1, 1'b0, 5'd1, 5'd2, 5'd15, 32'h00F, 1'b1});
    tbl.push_back('{32'h00511093, 4'h3, 1'b1, 1'b0, 5'd1, 5'd2, 5'd5, 32'h005, 1'b1});
    tbl.push_back('{32'h40511093, 4'h0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd5, 32'h405, 1'b0});
    tbl.push_back('{32'h00515093, 4'h4, 1'b1, 1'b0, 5'd1, 5'd2, 5'd5, 32'h005, 1'b1});
    tbl.push_back('{32'h40515093, 4'h5, 1'b1, 1'b0, 5'd1, 5'd2, 5'd5, 32'h405, 1'b1});
    tbl.push_back('{32'h02515093, 4'h0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd5, 32'h025, 1'b0});
    tbl.push_back('{32'h00000000, 4'h1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h000, 1'b1});
    tbl.push_back('{32'h00012083, 4'h1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 32'h000, 1'b1});

    // Reset held for 3 cycles with a pending request that must be ignored.
    rst = 1'b1; in_valid = 1'b1; inst = 32'h402081B3; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_state", pk(), ep(1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0));
    end
    rst = 1'b0;

    // Decode table at full throughput; the first accept is the first edge after release.
    foreach (tbl[i]) begin
      logic [63:0] a, e;
      in_valid = 1'b1; inst = tbl[i].inst; out_ready = 1'b1;
      tick();
      a = pk();
      e = ep(1'b1, 1'b1, tbl[i].alu, tbl[i].ui, tbl[i].il, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
      if (!tbl[i].ctl) begin
        a = a & ~CTL_MASK;
        e = e & ~CTL_MASK;
      end
      chk($sformatf("decode[%0d]", i), a, e);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_empty", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});

    // Backpressure: two accepted, third held off, outputs frozen.
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h003100B3;
    tick();
    chk("bp_first", pk(), ep(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h003));
    inst = 32'h402081B3;
    tick();
    chk("bp_full", pk(), ep(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h003));
    inst = 32'h407352B3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stable", pk(), ep(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h003));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_second", pk(), ep(1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h402));
    tick();
    chk("bp_third", pk(), ep(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 5'd5, 5'd6, 5'd7, 32'h407));
    in_valid = 1'b0;
    tick();
    chk("bp_drained", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});

    // Fill to TWO, then pulse reset between clock edges.
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'h003100B3;
    tick();
    inst = 32'h402081B3;
    tick();
    in_valid = 1'b0;
    chk("mid_two", {62'd0, in_ready, out_valid}, {62'd0, 1'b0, 1'b1});
    #2 rst = 1'b1;
    #1 chk("mid_rst_async", pk(), ep(1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0));
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_stale", {63'd0, out_valid}, 64'd0);
    end

    // Streaming with random backpressure: every bundle in order, exactly once.
    begin
      int sent = 0;
      int got = 0;
      logic acc, del;
      for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
        logic [11:0] v;
        v = sent[11:0];
        in_valid  = (sent < 100);
        inst      = {v, 5'd0, 3'b000, v[4:0], 7'h13};
        out_ready = 1'($urandom_range(0, 1));
        acc = in_valid && in_ready;
        del = out_valid && out_ready;
        if (del) begin
          chk($sformatf("stream[%0d]", got), {27'd0, alu_ctrl, use_imm, illegal, imm},
              {27'd0, 4'h1, 1'b1, 1'b0, 32'(got)});
          got++;
        end
        tick();
        if (acc) sent++;
      end
      in_valid = 1'b0;
      chk("stream_count", 64'(got), 64'd100);
`ifdef ALU_DECODE_STATS_EN
      chk("op_count", {48'd0, op_count}, 64'd100);
      chk("illegal_count", {48'd0, illegal_count}, 64'd0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
